// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand adder: operands are folded in carry-save form, one per cycle,
// then the redundant pair is resolved bit-serially and offered on a valid/ready port.
module csa_stream_accumulator #(
    parameter int W     = 4,
    parameter int ACC_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_cout,
    output logic [CNT_W-1:0] out_count
);

    localparam int IDX_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ACC_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [ACC_W-1:0] s_reg, c_reg;
    logic             ovf_reg;
    logic [CNT_W-1:0] count_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             rc_reg;
    logic [ACC_W-1:0] out_sum_reg;
    logic             out_cout_reg;
    logic [CNT_W-1:0] out_count_reg;

    logic [ACC_W-1:0] d_ext, xor_vec, maj_vec;
    logic             accept, taken;
    logic             s_bit, c_bit, sum_bit, rc_next;

    assign d_ext = {{(ACC_W-W){1'b0}}, in_data};

    // One full-adder column per accumulator bit; no carry chain between columns.
    genvar gi;
    generate
        for (gi = 0; gi < ACC_W; gi++) begin : g_csa
            assign xor_vec[gi] = s_reg[gi] ^ c_reg[gi] ^ d_ext[gi];
            assign maj_vec[gi] = (s_reg[gi] & c_reg[gi]) | (s_reg[gi] & d_ext[gi])
                               | (c_reg[gi] & d_ext[gi]);
        end
    endgenerate

    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == OUTPUT);
    assign accept    = in_valid && in_ready;
    assign taken     = out_valid && out_ready;

    assign s_bit   = s_reg[idx_reg];
    assign c_bit   = c_reg[idx_reg];
    assign sum_bit = s_bit ^ c_bit ^ rc_reg;
    assign rc_next = (s_bit & c_bit) | (s_bit & rc_reg) | (c_bit & rc_reg);

    assign out_sum   = out_sum_reg;
    assign out_cout  = out_cout_reg;
    assign out_count = out_count_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (accept && in_last)     state_next = RESOLVE;
            RESOLVE: if (idx_reg == IDX_LAST)   state_next = OUTPUT;
            OUTPUT:  if (out_ready)             state_next = ACCUM;
            default:                            state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= ACCUM;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg         <= '0;
            c_reg         <= '0;
            ovf_reg       <= 1'b0;
            count_reg     <= '0;
            idx_reg       <= '0;
            rc_reg        <= 1'b0;
            out_sum_reg   <= '0;
            out_cout_reg  <= 1'b0;
            out_count_reg <= '0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        s_reg <= xor_vec;
                        c_reg <= {maj_vec[ACC_W-2:0], 1'b0};
                        // The carry leaving the top column is worth 2^ACC_W; keep it sticky.
                        ovf_reg <= ovf_reg | maj_vec[ACC_W-1];
                        if (count_reg != CNT_MAX) count_reg <= count_reg + 1'b1;
                        if (in_last) begin
                            idx_reg <= '0;
                            rc_reg  <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    out_sum_reg[idx_reg] <= sum_bit;
                    rc_reg               <= rc_next;
                    idx_reg              <= idx_reg + 1'b1;
                    if (idx_reg == IDX_LAST) begin
                        out_cout_reg  <= ovf_reg | rc_next;
                        out_count_reg <= count_reg;
                    end
                end
                OUTPUT: begin
                    if (taken) begin
                        s_reg     <= '0;
                        c_reg     <= '0;
                        ovf_reg   <= 1'b0;
                        count_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed-vector bench for csa_stream_accumulator with hand-computed packet sums.
module tb_csa_stream_accumulator;

    localparam int W     = 4;
    localparam int ACC_W = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_cout;
    logic [CNT_W-1:0] out_count;

    int vec_cnt;
    int err_cnt;

    csa_stream_accumulator #(.W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Present one operand at a negedge; it is taken on the following posedge.
    task automatic push(input int d, input bit last);
        in_valid = 1'b1;
        in_data  = W'(d);
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called at the negedge right after the last operand was accepted.
    task automatic collect(input string tag, input int exp_sum, input int exp_cout,
                           input int exp_count, input int hold);
        int  k;
        bit  rdy_seen;
        rdy_seen = 1'b0;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (out_valid) break;
            if (in_ready) rdy_seen = 1'b1;
        end
        check({tag, " latency"}, k, ACC_W);
        check({tag, " in_ready low while resolving"}, int'(rdy_seen), 0);
        check({tag, " sum"}, int'(out_sum), exp_sum);
        check({tag, " cout"}, int'(out_cout), exp_cout);
        check({tag, " count"}, int'(out_count), exp_count);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " hold valid"}, int'(out_valid), 1);
            check({tag, " hold in_ready"}, int'(in_ready), 0);
            check({tag, " hold sum/cout/count"},
                  int'({out_sum, out_cout, out_count}),
                  int'({exp_sum[ACC_W-1:0], exp_cout[0], exp_count[CNT_W-1:0]}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " valid drops after take"}, int'(out_valid), 0);
        check({tag, " back to accum"}, int'(in_ready), 1);
    endtask

    initial begin
        bit vseen;
        vec_cnt   = 0;
        err_cnt   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out_valid", int'(out_valid), 0);
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_sum", int'(out_sum), 0);
        check("reset out_cout", int'(out_cout), 0);
        check("reset out_count", int'(out_count), 0);
        rst = 1'b0;
        @(negedge clk);

        // 10,0,0,0
        push(10, 0); push(0, 0); push(0, 0); push(0, 1);
        collect("pkt 10+0+0+0", 10, 0, 4, 0);

        // Back-to-back 4,6,12,0 then 11,2,4,7
        push(4, 0); push(6, 0); push(12, 0); push(0, 1);
        collect("pkt 4+6+12+0", 22, 0, 4, 0);
        push(11, 0); push(2, 0); push(4, 0); push(7, 1);
        collect("pkt 11+2+4+7", 24, 0, 4, 0);

        push(15, 0); push(15, 0); push(15, 0); push(15, 1);
        collect("pkt 4x15", 60, 0, 4, 0);
        push(7, 1);
        collect("pkt single 7", 7, 0, 1, 0);

        // 20 x 15 = 300 -> 44 with overflow
        for (int i = 0; i < 20; i++) push(15, i == 19);
        collect("pkt 20x15", 44, 1, 20, 0);

        // Backpressure for 5 cycles
        push(12, 0); push(5, 0); push(10, 0); push(10, 1);
        collect("pkt 12+5+10+10 stalled", 37, 0, 4, 5);

        // Reset in the middle of resolving
        push(7, 0); push(6, 0); push(12, 0); push(8, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort out_valid", int'(out_valid), 0);
        check("abort in_ready", int'(in_ready), 1);
        check("abort out_sum", int'(out_sum), 0);
        check("abort out_cout", int'(out_cout), 0);
        check("abort out_count", int'(out_count), 0);
        vseen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) vseen = 1'b1;
        end
        check("abort emits nothing", int'(vseen), 0);
        push(1, 0); push(2, 1);
        collect("pkt 1+2 after abort", 3, 0, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
- Sequential multi-operand adder. Accepts a packet of W-bit unsigned operands over a valid/ready stream.
- Accumulates operands in carry-save form, one operand per cycle, with no carry propagation.
- On the last operand, resolves the redundant sum/carry pair to binary using a bit-serial ripple FSM, one bit per cycle.
- Presents the result on a valid/ready output port. Serves as the receiving and resolving end of the team's carry-save adder datapath.

Parameters:
- W, 4, operand width in bits.
- ACC_W, 8, accumulator and result width in bits; ACC_W > W.
- CNT_W, 8, operand-count width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- in_data  input  W  unsigned operand.
- in_last  input  1  marks the final operand of the packet; qualified by the handshake.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  binary sum modulo 2^ACC_W.
- out_cout  output  1  overflow: set when the true sum is >= 2^ACC_W.
- out_count  output  CNT_W  number of operands in the packet; saturates at 2^CNT_W-1.

Behaviour:
- States: ACCUM, RESOLVE, OUTPUT. Reset state is ACCUM.
- Reset values: S=0, C=0, ovf=0, count=0, bit index=0, ripple carry=0, out_sum=0, out_cout=0, out_count=0, out_valid=0, in_ready=1.
- Reset asserted in any state, including mid-RESOLVE or mid-OUTPUT, aborts the packet. Nothing is emitted.
- ACCUM:
  - in_ready=1. An operand is accepted when in_valid && in_ready.
  - On accept, D = zero-extended in_data.
  - S <= S^C^D.
  - C <= ((S&C)|(S&D)|(C&D)) << 1.
  - Bit ACC_W-1 of the majority vector is shifted out and ORed into the sticky ovf.
  - count <= count+1, saturating.
  - If in_last is set on the accepting edge, go to RESOLVE with bit index=0 and ripple carry=0.
- RESOLVE:
  - in_ready=0; in_valid is ignored.
  - Each cycle processes bit i: out_sum[i] <= S[i]^C[i]^rc and rc <= majority(S[i],C[i],rc), then i <= i+1.
  - After bit ACC_W-1 is processed: out_cout <= ovf | final rc, out_count <= count, then go to OUTPUT.
- OUTPUT:
  - out_valid=1; in_ready=0.
  - out_sum, out_cout and out_count are held stable while out_valid && !out_ready.
  - On out_ready: out_valid drops on the next edge, S/C/ovf/count clear, and the state returns to ACCUM.
  - A new operand is not accepted on the same edge that the result is taken.
- Latency:
  - out_valid is first high after exactly ACC_W rising edges following the edge that accepted the in_last operand (8 with defaults).
  - Throughput is 1 operand/cycle in ACCUM.
- Single-operand packet (in_last set on the first operand) is legal; the result equals that operand and count is 1.
- in_last is ignored unless the handshake occurs.
- Holding in_valid with unchanging data across cycles in ACCUM counts as multiple operands; the upstream is responsible for handshake discipline.
- out_sum and out_cout are only meaningful while out_valid=1. out_sum is written bit by bit during RESOLVE.
- Arithmetic is unsigned. The invariant S + C + ovf·2^ACC_W equals the true sum so far; out_cout is exact for sums below 2^(ACC_W+1).

Test Plan:
- Packet 10,0,0,0 (last on 4th) with out_ready=1 -> out_sum=10, out_cout=0, out_count=4; out_valid rises 8 edges after the last accept.
- Packets 4,6,12,0 then 11,2,4,7 back-to-back -> 22 then 24; count=4 each; in_ready=0 during RESOLVE/OUTPUT of each packet.
- Packet 15,15,15,15 -> out_sum=60, out_cout=0. Then a single operand 7 with in_last -> out_sum=7, out_count=1.
- 20 operands of 15 -> true sum 300; expect out_sum=44, out_cout=1, out_count=20.
- Packet 12,5,10,10 with out_ready=0 for 5 cycles after out_valid -> outputs hold 37/0/4 stable, in_ready stays 0; release -> one-cycle handshake, then back to ACCUM.
- Reset pulsed during RESOLVE of packet 7,6,12,8 -> no out_valid; all outputs at reset values. A following packet 1,2 -> out_sum=3, count=2.
